// File: rtl/core_pkg.sv
// ============================================================================
// Module : core_pkg
// Brief  : Shared constants for the RV32I core pipeline stages.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package core_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// ============================================================================
// Module : load_align
// Brief  : Combinational load lane select, sign/zero extension and
//          misalignment detection.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module load_align
    import core_pkg::*;
#(
    parameter int XLEN = core_pkg::XLEN
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] data,
    output logic            misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte   = word[{addr, 3'b000} +: 8];
        w_half   = addr[1] ? word[31:16] : word[15:0];
        data     = word;
        misalign = 1'b0;
        unique case (funct3)
            F3_LB:  data = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_LBU: data = {{(XLEN-8){1'b0}}, w_byte};
            F3_LH: begin
                data     = {{(XLEN-16){w_half[15]}}, w_half};
                misalign = addr[0];
            end
            F3_LHU: begin
                data     = {{(XLEN-16){1'b0}}, w_half};
                misalign = addr[0];
            end
            F3_LW:  misalign = |addr;
            // Undefined encodings fall through with the raw word.
            default: data = word;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
// ============================================================================
// Module : wb_stage
// Brief  : MEM/WB pipeline register, load writeback datapath and
//          retired-instruction counter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wb_stage
    import core_pkg::*;
#(
    parameter int XLEN      = core_pkg::XLEN,
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_valid,
    input  logic                 mem_flush,
    input  logic                 mem_reg_write,
    input  logic [4:0]           mem_rd,
    input  logic [1:0]           mem_wb_sel,
    input  logic [2:0]           mem_funct3,
    input  logic [XLEN-1:0]      mem_alu_result,
    input  logic [XLEN-1:0]      mem_pc_plus4,
    input  logic [XLEN-1:0]      dmem_rdata,
    output logic                 rf_we,
    output logic [4:0]           rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic                 wb_fwd_valid,
    output logic                 load_misalign,
    output logic [INSTRET_W-1:0] instret
);

    logic                 r_wbValid;
    logic                 r_wbRegWrite;
    logic [4:0]           r_wbRd;
    logic [1:0]           r_wbSel;
    logic [2:0]           r_wbFunct3;
    logic [XLEN-1:0]      r_wbAluResult;
    logic [XLEN-1:0]      r_wbPcPlus4;
    logic [INSTRET_W-1:0] r_instret;

    logic [XLEN-1:0]      w_loadData;
    logic                 w_alignFault;
    logic                 w_misalign;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wbValid     <= 1'b0;
            r_wbRegWrite  <= 1'b0;
            r_wbRd        <= '0;
            r_wbSel       <= WB_SEL_ALU;
            r_wbFunct3    <= '0;
            r_wbAluResult <= '0;
            r_wbPcPlus4   <= '0;
            r_instret     <= '0;
        end else begin
            r_wbValid     <= mem_valid & ~mem_flush;
            r_wbRegWrite  <= mem_reg_write;
            r_wbRd        <= mem_rd;
            r_wbSel       <= mem_wb_sel;
            r_wbFunct3    <= mem_funct3;
            r_wbAluResult <= mem_alu_result;
            r_wbPcPlus4   <= mem_pc_plus4;
            // Misaligned loads still retire; wrap is silent.
            r_instret     <= r_instret + {{(INSTRET_W-1){1'b0}}, r_wbValid};
        end
    end

    load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .funct3   (r_wbFunct3),
        .addr     (r_wbAluResult[1:0]),
        .word     (dmem_rdata),
        .data     (w_loadData),
        .misalign (w_alignFault)
    );

    assign w_misalign = r_wbValid & (r_wbSel == WB_SEL_MEM) & w_alignFault;

    always_comb begin
        unique case (r_wbSel)
            WB_SEL_MEM: rf_wdata = w_loadData;
            WB_SEL_PC4: rf_wdata = r_wbPcPlus4;
            default:    rf_wdata = r_wbAluResult;
        endcase
    end

    assign rf_we         = r_wbValid & r_wbRegWrite & (r_wbRd != 5'd0) & ~w_misalign;
    assign rf_waddr      = r_wbRd;
    assign wb_fwd_valid  = rf_we;
    assign load_misalign = w_misalign;
    assign instret       = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// ============================================================================
// Module : tb_wb_stage
// Brief  : Directed scoreboard bench for the writeback stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_wb_stage;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        chkData;
        logic        mis;
        logic [63:0] instret;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid, mem_flush, mem_reg_write;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wb_sel;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_alu_result, mem_pc_plus4, dmem_rdata;
    logic        rf_we, wb_fwd_valid, load_misalign;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [63:0] instret;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [63:0] mCnt  = 0;

    wb_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_valid      (mem_valid),
        .mem_flush      (mem_flush),
        .mem_reg_write  (mem_reg_write),
        .mem_rd         (mem_rd),
        .mem_wb_sel     (mem_wb_sel),
        .mem_funct3     (mem_funct3),
        .mem_alu_result (mem_alu_result),
        .mem_pc_plus4   (mem_pc_plus4),
        .dmem_rdata     (dmem_rdata),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .wb_fwd_valid   (wb_fwd_valid),
        .load_misalign  (load_misalign),
        .instret        (instret)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one MEM-stage slot, clock it into WB, then score the WB cycle.
    task automatic step(input string tag, input logic v, input logic f, input logic rw,
                        input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] pc4,
                        input logic eWe, input logic eMis, input logic cd,
                        input logic [31:0] eData);
        exp_t e;
        exp_t o;
        mem_valid      = v;
        mem_flush      = f;
        mem_reg_write  = rw;
        mem_rd         = rd;
        mem_wb_sel     = sel;
        mem_funct3     = f3;
        mem_alu_result = alu;
        mem_pc_plus4   = pc4;
        e.we      = eWe;
        e.waddr   = rd;
        e.wdata   = eData;
        e.chkData = cd;
        e.mis     = eMis;
        e.instret = mCnt;
        if (v && !f) mCnt = mCnt + 1;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        tests++;
        assert (sb.size() != 0) else begin
            fails++;
            $error("FAIL %s_sb obs=empty exp=entry", tag);
        end
        if (sb.size() != 0) begin
            o = sb.pop_front();
            chk({tag, "_we"},   {63'd0, rf_we},         {63'd0, o.we});
            chk({tag, "_fwd"},  {63'd0, wb_fwd_valid},  {63'd0, o.we});
            chk({tag, "_mis"},  {63'd0, load_misalign}, {63'd0, o.mis});
            chk({tag, "_addr"}, {59'd0, rf_waddr},      {59'd0, o.waddr});
            if (o.chkData) chk({tag, "_data"}, {32'd0, rf_wdata}, {32'd0, o.wdata});
            chk({tag, "_cnt"},  instret,                o.instret);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        dmem_rdata = 32'h80FF_7F01;
        mem_valid = 0; mem_flush = 0; mem_reg_write = 0; mem_rd = 0;
        mem_wb_sel = 0; mem_funct3 = 0; mem_alu_result = 0; mem_pc_plus4 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_we",   {63'd0, rf_we},         64'd0);
        chk("rst_fwd",  {63'd0, wb_fwd_valid},  64'd0);
        chk("rst_mis",  {63'd0, load_misalign}, 64'd0);
        chk("rst_addr", {59'd0, rf_waddr},      64'd0);
        chk("rst_data", {32'd0, rf_wdata},      64'd0);
        chk("rst_cnt",  instret,                64'd0);
        rst_n = 1'b1;

        //    tag      v  f  rw rd     sel    f3      alu           pc4        we mis cd data
        step("alu",   1, 0, 1, 5'd5,  2'b00, 3'b000, 32'h0000_1234, 32'h0,    1, 0, 1, 32'h0000_1234);
        step("lb",    1, 0, 1, 5'd6,  2'b01, 3'b000, 32'h1000_0003, 32'h0,    1, 0, 1, 32'hFFFF_FF80);
        step("lbu",   1, 0, 1, 5'd6,  2'b01, 3'b100, 32'h1000_0001, 32'h0,    1, 0, 1, 32'h0000_007F);
        step("lh",    1, 0, 1, 5'd6,  2'b01, 3'b001, 32'h1000_0002, 32'h0,    1, 0, 1, 32'hFFFF_80FF);
        step("lhu",   1, 0, 1, 5'd6,  2'b01, 3'b101, 32'h1000_0000, 32'h0,    1, 0, 1, 32'h0000_7F01);
        step("lw",    1, 0, 1, 5'd6,  2'b01, 3'b010, 32'h1000_0000, 32'h0,    1, 0, 1, 32'h80FF_7F01);
        step("lwmis", 1, 0, 1, 5'd7,  2'b01, 3'b010, 32'h1000_0002, 32'h0,    0, 1, 0, 32'h0);
        step("lhmis", 1, 0, 1, 5'd7,  2'b01, 3'b101, 32'h1000_0003, 32'h0,    0, 1, 0, 32'h0);
        step("x0",    1, 0, 1, 5'd0,  2'b00, 3'b000, 32'h0000_0077, 32'h0,    0, 0, 1, 32'h0000_0077);
        step("jal",   1, 0, 1, 5'd1,  2'b10, 3'b000, 32'h0000_DEAD, 32'h104,  1, 0, 1, 32'h0000_0104);
        step("rsvd",  1, 0, 1, 5'd2,  2'b11, 3'b000, 32'h0000_0ABC, 32'h200,  1, 0, 1, 32'h0000_0ABC);
        step("flush", 1, 1, 1, 5'd9,  2'b00, 3'b000, 32'h0000_0055, 32'h0,    0, 0, 1, 32'h0000_0055);
        step("nowr",  1, 0, 0, 5'd3,  2'b00, 3'b000, 32'h0000_0066, 32'h0,    0, 0, 1, 32'h0000_0066);
        for (int i = 0; i < 3; i++)
            step("bub", 0, 0, 1, 5'd4, 2'b00, 3'b000, 32'h0000_0011, 32'h0,   0, 0, 1, 32'h0000_0011);
        step("b2b0",  1, 0, 1, 5'd10, 2'b00, 3'b000, 32'h0000_00A0, 32'h0,    1, 0, 1, 32'h0000_00A0);
        step("b2b1",  1, 0, 1, 5'd11, 2'b00, 3'b000, 32'h0000_00A1, 32'h0,    1, 0, 1, 32'h0000_00A1);

        // Reset while a valid instruction is being captured discards it.
        rst_n = 1'b0;
        mem_valid = 1; mem_reg_write = 1; mem_rd = 5'd12; mem_alu_result = 32'hBEEF;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_we",   {63'd0, rf_we},    64'd0);
        chk("mrst_addr", {59'd0, rf_waddr}, 64'd0);
        chk("mrst_data", {32'd0, rf_wdata}, 64'd0);
        chk("mrst_cnt",  instret,           64'd0);
        rst_n = 1'b1;
        mCnt = 0;
        step("post",  1, 0, 1, 5'd13, 2'b00, 3'b000, 32'h0000_0C0D, 32'h0,    1, 0, 1, 32'h0000_0C0D);
        step("post2", 0, 0, 0, 5'd0,  2'b00, 3'b000, 32'h0,         32'h0,    0, 0, 1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register plus writeback datapath of the 5-stage RV32I core.
- Captures MEM-stage results and aligns/extends the raw data-memory load word.
- Drives the register file write port (write-enable, write-address, write-data) and the WB forwarding path.
- Counts retired instructions.

Parameters:
- XLEN, 32, datapath width.
- INSTRET_W, 64, width of retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset; synchronous, active-low.
- mem_valid  in  1  MEM stage presents an instruction this cycle.
- mem_flush  in  1  kill the incoming MEM instruction (trap/redirect).
- mem_reg_write  in  1  instruction writes rd.
- mem_rd  in  5  destination register.
- mem_wb_sel  in  2  00=ALU result, 01=load data, 10=PC+4, 11=reserved (treated as ALU).
- mem_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- mem_alu_result  in  XLEN  ALU result / load byte address.
- mem_pc_plus4  in  XLEN  link value.
- dmem_rdata  in  XLEN  raw aligned word from synchronous data memory, valid in the WB cycle.
- rf_we  out  1  register file write enable.
- rf_waddr  out  5  register file write address.
- rf_wdata  out  XLEN  register file write data.
- wb_fwd_valid  out  1  forwarding source valid (equals rf_we).
- load_misalign  out  1  one-cycle pulse: misaligned load dropped.
- instret  out  INSTRET_W  retired-instruction count.

Behaviour:
- Reset (rst_n=0 at posedge): valid, rd, wb_sel, funct3 and all data registers cleared; instret=0. Outputs then: rf_we=0, rf_waddr=0, rf_wdata=0, wb_fwd_valid=0, load_misalign=0.
- Capture: each posedge, wb_valid <= mem_valid & ~mem_flush. Payload fields load unconditionally.
- Flush wins over valid; a flushed slot is a bubble.
- WB never stalls. One instruction per cycle.
- Latency: accepted in MEM at cycle N, WB outputs in cycle N+1, register file written at the posedge ending N+1. rf_wdata is combinational from WB registers and dmem_rdata.
- Misalignment check in WB:
  - LH/LHU with addr[0]=1 is misaligned.
  - LW with addr[1:0]!=0 is misaligned.
  - Misaligned loads have rf_we forced to 0 and load_misalign=1 for that cycle only.
  - Misaligned loads are still counted as retired.
- Load extraction: byte lane = addr[1:0], halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Undefined funct3 values (011, 110, 111) return the word unchanged.
- rf_we = wb_valid & wb_reg_write & (wb_rd != 0) & ~misalign. Writes to x0 are never issued.
- When rf_we=0: rf_waddr and rf_wdata still show the WB values. Consumers must qualify with rf_we.
- instret: increments by 1 at the posedge ending every cycle with wb_valid=1. Wraps modulo 2^INSTRET_W with no flag.
- Reset mid-operation: the in-flight WB instruction is discarded and not counted.

Decomposition:
- Shared package core_pkg:
  - WB_SEL_ALU/MEM/PC4 encodings.
  - LOAD funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - XLEN.
- One sub-module, load_align: purely combinational. Inputs funct3, addr[1:0], raw word. Outputs extended data and a misalign flag.

Test Plan:
- ALU writeback: mem_valid=1, rd=5, wb_sel=00, alu=0x0000_1234 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x0000_1234; instret 0→1.
- Loads, dmem_rdata=0x80FF_7F01:
  - LB addr=...3 → 0xFFFF_FF80.
  - LBU addr=...1 → 0x0000_007F.
  - LH addr=...2 → 0xFFFF_80FF.
  - LHU addr=...0 → 0x0000_7F01.
  - LW addr=...0 → 0x80FF_7F01.
- Misaligned: LW addr=0x...2, rd=7 → rf_we=0, load_misalign=1 for one cycle, instret still increments.
- x0/link: rd=0, reg_write=1 → rf_we=0, instret counts. JAL with rd=1, wb_sel=10, pc4=0x104 → rf_wdata=0x104, rf_we=1.
- Flush/bubble: mem_valid=1 with mem_flush=1 → rf_we=0, instret unchanged. mem_valid=0 for 3 cycles → no writes.
- Reset mid-stream: back-to-back valid instructions, rst_n=0 for one posedge → all outputs 0 and instret=0 next cycle; the following valid instruction writes normally.
